// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared constants, FSM encoding and width helpers for the multiplier arbiter
package mul_arbiter_pkg;
   localparam int MUL_LAT = 34;
   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction
endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// mul_arbiter_rr_pick: round-robin picker, first eligible index after ptr wins (one-hot)
module mul_arbiter_rr_pick
   import mul_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]        elig,
   input  logic [idx_w(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]        grant
);
   localparam int PW = idx_w(NREQ);
   logic [PW-1:0] idx;
   logic          found;
   // scan ptr+1, ptr+2, ... modulo NREQ and grant the first eligible requester
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && elig[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential run/stall multiplier among NREQ requesters
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*32-1:0] req_x,
   input  logic [NREQ*32-1:0] req_y,
   input  logic [NREQ-1:0]   req_u,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [NREQ*64-1:0] resp_z,
   output logic              mul_run,
   output logic              mul_u,
   output logic [31:0]       mul_x,
   output logic [31:0]       mul_y,
   input  logic              mul_stall,
   input  logic [63:0]       mul_z,
   output logic              busy,
   output logic              err
);
   localparam int PW = idx_w(NREQ);
   localparam int CW = cnt_w(TIMEOUT);
   state_t                 state, next_state;
   logic [PW-1:0]          ptr, tag, gidx;
   logic [CW-1:0]          cnt;
   logic [31:0]            op_x, op_y;
   logic                   op_u;
   logic [NREQ-1:0]        pick, grant;
   logic [NREQ-1:0][31:0]  x_arr, y_arr;
   logic [NREQ-1:0][63:0]  res_z;
   logic                   xfer, done, abort;
   assign x_arr = req_x;
   assign y_arr = req_y;
   mul_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
      .elig  (req_valid & ~resp_valid),
      .ptr   (ptr),
      .grant (pick)
   );
   assign grant     = (state == IDLE) ? pick : '0;
   assign req_ready = grant;
   assign xfer      = |(req_valid & grant);
   assign done      = (state == RUN) && !mul_stall;
   assign abort     = (state == RUN) && mul_stall && (cnt == CW'(TIMEOUT - 1));
   assign mul_run   = (state == RUN);
   assign mul_x     = op_x;
   assign mul_y     = op_y;
   assign mul_u     = op_u;
   assign busy      = (state != IDLE);
   assign resp_z    = res_z;
   // binary index of the one-hot pick
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NREQ; i++)
         if (pick[i]) gidx = PW'(i);
   end
   // next state: one operation runs, then one idle GAP cycle lets the multiplier clear
   always_comb begin
      next_state = state;
      next_state = (state == IDLE) ? (xfer ? RUN : IDLE) :
                   (state == RUN)  ? ((done || abort) ? GAP : RUN) : IDLE;
   end
   // state, operand latches, run counter, result capture and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= PW'(NREQ - 1);
         tag        <= '0;
         cnt        <= '0;
         op_x       <= '0;
         op_y       <= '0;
         op_u       <= 1'b0;
         resp_valid <= '0;
         res_z      <= '0;
         err        <= 1'b0;
      end else begin
         state      <= next_state;
         resp_valid <= (resp_valid & ~resp_ready) | ((done || abort) ? (NREQ'(1) << tag) : '0);
         if (xfer) begin
            op_x <= x_arr[gidx];
            op_y <= y_arr[gidx];
            op_u <= req_u[gidx];
            tag  <= gidx;
            ptr  <= gidx;
            cnt  <= '0;
         end
         if (state == RUN) cnt <= cnt + CW'(1);
         if (done) res_z[tag] <= mul_z;
         else if (abort) res_z[tag] <= '0;
         if (abort) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed checks of the multiplier arbiter against a behavioural multiplier
module tb_mul_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid, req_ready, req_u, resp_valid, resp_ready;
   logic [63:0]  req_x, req_y;
   logic [127:0] resp_z;
   logic         mul_run, mul_u, mul_stall, busy, err;
   logic [31:0]  mul_x, mul_y;
   logic [63:0]  mul_z;
   logic signed [63:0] sx, sy;
   int  vectors = 0, miss = 0, mcnt = 0, cyc = 0;
   bit  stuck = 1'b0;
   logic [63:0] z;
   int  runs, sl, ok, n;
   int  gcyc[4];
   logic [3:0] gseq;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // multiplier model: product valid on the 34th consecutive run cycle
   always @(posedge clk) mcnt <= mul_run ? mcnt + 1 : 0;
   assign sx        = {{32{mul_x[31]}}, mul_x};
   assign sy        = {{32{mul_y[31]}}, mul_y};
   assign mul_z     = mul_u ? sx * sy : {32'b0, mul_x} * {32'b0, mul_y};
   assign mul_stall = stuck | !(mul_run && mcnt == 33);

   mul_arbiter #(.NREQ(2), .TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_u(req_u), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_z(resp_z), .mul_run(mul_run), .mul_u(mul_u),
      .mul_x(mul_x), .mul_y(mul_y), .mul_stall(mul_stall), .mul_z(mul_z),
      .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input int i, input logic [31:0] x, input logic [31:0] y,
                         input bit u, output logic [63:0] zo);
      int got;
      @(posedge clk); #1;
      req_x[32*i +: 32] = x;
      req_y[32*i +: 32] = y;
      req_u[i]          = u;
      req_valid[i]      = 1'b1;
      got = 0;
      for (int k = 0; k < 100 && got == 0; k++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1;
      end
      chk("op_grant", 64'(got), 64'd1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      got = 0;
      for (int k = 0; k < 100 && got == 0; k++) begin
         @(negedge clk);
         if (resp_valid[i]) got = 1;
      end
      chk("op_resp", 64'(got), 64'd1);
      zo = resp_z[64*i +: 64];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_u = '0; resp_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mul_run", mul_run, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_resp_z0", resp_z[63:0], 0);
      chk("rst_resp_z1", resp_z[127:64], 0);
      @(posedge clk); #1 rst = 1'b0;
      // 1: both valid, req0 wins first; 7*6 with exact run/response timing
      @(posedge clk); #1;
      req_x = {32'd1, 32'd7}; req_y = {32'd1, 32'd6}; req_u = 2'b00; req_valid = 2'b11;
      @(negedge clk);
      chk("t1_ready", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      runs = 0; sl = 0;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (mul_run) runs++;
         if (!mul_stall && sl == 0) sl = k;
         if (k == 1) chk("t1_mul_xy", {mul_x, mul_y}, {32'd7, 32'd6});
      end
      chk("t1_run_cycles", 64'(runs), 64'd34);
      chk("t1_stall_low_at", 64'(sl), 64'd34);
      @(negedge clk);
      chk("t1_run_off", mul_run, 0);
      chk("t1_resp_valid", resp_valid, 2'b01);
      chk("t1_resp_z", resp_z[63:0], 64'h2A);
      chk("t1_busy_gap", busy, 1);
      resp_ready = 2'b01;
      @(negedge clk);
      chk("t1_consumed", resp_valid, 2'b00);
      chk("t1_z_hold", resp_z[63:0], 64'h2A);
      chk("t1_idle", busy, 0);
      // 2: signed and unsigned corner products
      resp_ready = 2'b11;
      run_op(1, 32'hFFFF_FFFD, 32'd5, 1'b1, z);
      chk("t2_neg3x5", z, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, z);
      chk("t2_umax_sq", z, 64'hFFFF_FFFE_0000_0001);
      run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, z);
      chk("t2_sneg1_sq", z, 64'h1);
      chk("t2_err", err, 0);
      // 3: both always valid -> alternating grants, 36 cycles apart
      @(posedge clk); #1;
      req_x = {32'd5, 32'd3}; req_y = {32'd6, 32'd4}; req_u = 2'b00; req_valid = 2'b11;
      n = 0; gseq = '0;
      for (int k = 0; k < 300 && n < 4; k++) begin
         @(negedge clk);
         if (|(req_valid & req_ready)) begin
            gcyc[n] = cyc;
            gseq[n] = req_ready[1];
            n++;
         end
      end
      @(posedge clk); #1 req_valid = 2'b00;
      chk("t3_count", 64'(n), 64'd4);
      chk("t3_order", gseq, 4'b1010);
      chk("t3_gap01", 64'(gcyc[1] - gcyc[0]), 64'd36);
      chk("t3_gap12", 64'(gcyc[2] - gcyc[1]), 64'd36);
      chk("t3_gap23", 64'(gcyc[3] - gcyc[2]), 64'd36);
      ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      chk("t3_drain", 64'(ok), 64'd1);
      chk("t3_z0", resp_z[63:0], 64'd12);
      chk("t3_z1", resp_z[127:64], 64'd30);
      // 4: req0 withholds resp_ready -> req1 served, req0 blocked until consumed
      resp_ready = 2'b10;
      @(posedge clk); #1;
      req_x = {32'd2, 32'd10}; req_y = {32'd2, 32'd11}; req_valid = 2'b11;
      @(negedge clk);
      chk("t4_first", req_ready, 2'b01);
      ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
         @(negedge clk);
         if (resp_valid[0]) ok = 1;
      end
      chk("t4_resp0", 64'(ok), 64'd1);
      @(negedge clk);
      chk("t4_grant1", req_ready, 2'b10);
      ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
         @(negedge clk);
         if (resp_valid[1]) ok = 1;
      end
      chk("t4_resp1", 64'(ok), 64'd1);
      @(negedge clk);
      chk("t4_blocked", req_ready, 2'b10);
      chk("t4_pending", resp_valid, 2'b01);
      chk("t4_z0_hold", resp_z[63:0], 64'd110);
      req_valid = 2'b00;
      @(negedge clk);
      chk("t4_held", req_ready, 2'b00);
      req_x[31:0] = 32'd2; req_y[31:0] = 32'd3; req_valid = 2'b01; resp_ready = 2'b11;
      #1;
      chk("t4_bubble", req_ready, 2'b00);
      @(negedge clk);
      chk("t4_released", resp_valid, 2'b00);
      chk("t4_regrant", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
         @(negedge clk);
         if (resp_valid[0]) ok = 1;
      end
      chk("t4_resp0b", 64'(ok), 64'd1);
      chk("t4_z0b", resp_z[63:0], 64'd6);
      // 5: multiplier never finishes -> abort after 40 run cycles, err sticky
      stuck = 1'b1;
      @(posedge clk); #1;
      req_x[63:32] = 32'd9; req_y[63:32] = 32'd9; req_u = 2'b00; req_valid = 2'b10;
      @(negedge clk);
      chk("t5_ready", req_ready, 2'b10);
      @(posedge clk); #1 req_valid = 2'b00;
      runs = 0; ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
         @(negedge clk);
         if (mul_run) runs++;
         if (resp_valid[1]) ok = 1;
      end
      chk("t5_resp", 64'(ok), 64'd1);
      chk("t5_run_cycles", 64'(runs), 64'd40);
      chk("t5_z_zero", resp_z[127:64], 64'd0);
      chk("t5_err", err, 1);
      stuck = 1'b0;
      run_op(0, 32'd100, 32'd3, 1'b0, z);
      chk("t5_after", z, 64'd300);
      chk("t5_sticky", err, 1);
      // 6: reset in the middle of an operation, then a clean operation
      @(posedge clk); #1;
      req_x[31:0] = 32'd5; req_y[31:0] = 32'd5; req_valid = 2'b01;
      @(negedge clk);
      chk("t6_ready", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t6_run_before", mul_run, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_run_off", mul_run, 0);
      chk("t6_idle", busy, 0);
      chk("t6_err_cleared", err, 0);
      ok = 0;
      repeat (45) begin
         @(negedge clk);
         if (resp_valid != 2'b00) ok = 1;
      end
      chk("t6_no_resp", 64'(ok), 64'd0);
      run_op(0, 32'd100, 32'd200, 1'b0, z);
      chk("t6_after", z, 64'd20000);
      chk("t6_err", err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end
endmodule
